// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scan multiplexer.
// Latency: n/a (no logic).
// Backpressure: n/a.
package scan_mux_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } scan_state_t;

    // Ceiling log2 of n (0 for n <= 1); constant-evaluable.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Index width for an n-entry range; never narrower than one bit.
    function automatic int sel_width(input int n);
        int w;
        w = clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/scan_mux_key_edge.sv
// Push-button front end: two-flop synchroniser plus falling-edge press pulse.
// Latency: pin fall to press pulse = 2 cycles; pulse is combinational from the flops, 1 cycle wide.
// Backpressure: none; the key is sampled every cycle and a held key yields one pulse.
//
// Ports:
//   clk    - clock
//   rst    - synchronous active-high reset
//   key_n  - raw active-low key pin, asynchronous to clk
//   press  - one-cycle pulse per synchronised falling edge
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic sync1;
    logic sync2;
    logic prev;
    // fill1/fill2 mark that sync2 holds a real pin sample rather than the
    // reset value; armed is only set once a genuine "released" level is seen,
    // so a key held down across reset cannot look like a fresh press.
    logic fill1;
    logic fill2;
    logic armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
            fill1 <= 1'b0;
            fill2 <= 1'b0;
            armed <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            prev  <= sync2;
            fill1 <= 1'b1;
            fill2 <= fill1;
            armed <= armed | (fill2 & sync2);
        end
    end

    assign press = armed & prev & ~sync2;

endmodule

// File: rtl/scan_mux.sv
// Channel multiplexer with manual key stepping, timed auto-scan and direct load.
// Latency: sel to f and din to f = 1 cycle; key pin fall to sel = 3 cycles, to f = 4 cycles.
// Backpressure: none; every input is sampled each cycle, outputs are always valid.
//
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   din         - CHANNELS packed channels, channel i at [i*WIDTH +: WIDTH]
//   key_next_n  - active-low async key, steps the selection in MANUAL
//   key_mode_n  - active-low async key, toggles MANUAL/AUTO
//   load/sel_in - synchronous direct selection load (ignored if out of range)
//   f           - registered data of the selected channel
//   sel/disp    - current channel index, and the same zero-extended to 4 bits
//   auto_on     - high while auto-scanning
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int CHANNELS = 4,
    parameter  int SCAN_DIV = 50_000_000,
    localparam int SELW     = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      key_next_n,
    input  logic                      key_mode_n,
    input  logic                      load,
    input  logic [SELW-1:0]           sel_in,
    output logic [WIDTH-1:0]          f,
    output logic [SELW-1:0]           sel,
    output logic [3:0]                disp,
    output logic                      auto_on
);

    localparam int              PW         = sel_width(SCAN_DIV);
    localparam logic [SELW:0]   CH_LIM     = (SELW+1)'(CHANNELS);
    localparam logic [SELW-1:0] SEL_LAST   = SELW'(CHANNELS - 1);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);

    logic next_press;
    logic mode_press;

    key_edge u_key_next (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_next_n),
        .press (next_press)
    );

    key_edge u_key_mode (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_mode_n),
        .press (mode_press)
    );

    scan_state_t     state;
    scan_state_t     state_d;
    logic [SELW-1:0] sel_q;
    logic [SELW-1:0] sel_d;
    logic [SELW-1:0] sel_inc;
    logic [PW-1:0]   presc;
    logic [PW-1:0]   presc_d;
    logic            load_ok;

    // Out-of-range loads are dropped entirely, so they also leave the
    // lower-priority mode/advance logic free to act in that cycle.
    assign load_ok = load && ({1'b0, sel_in} < CH_LIM);

    // Compare with >= so a non-power-of-two channel count still wraps cleanly.
    assign sel_inc = (sel_q >= SEL_LAST) ? '0 : sel_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MANUAL;
            sel_q <= '0;
            presc <= '0;
            f     <= '0;
        end else begin
            state <= state_d;
            sel_q <= sel_d;
            presc <= presc_d;
            f     <= din[int'(sel_q)*WIDTH +: WIDTH];
        end
    end

    // Priority: valid load, then mode toggle, then the per-state advance.
    always_comb begin
        state_d = state;
        sel_d   = sel_q;
        presc_d = presc;
        if (load_ok) begin
            sel_d   = sel_in;
            presc_d = '0;
        end else if (mode_press) begin
            state_d = (state == AUTO) ? MANUAL : AUTO;
            presc_d = '0;
        end else begin
            case (state)
                MANUAL: begin
                    presc_d = '0;
                    if (next_press) begin
                        sel_d = sel_inc;
                    end
                end
                AUTO: begin
                    if (presc >= PRESC_LAST) begin
                        presc_d = '0;
                        sel_d   = sel_inc;
                    end else begin
                        presc_d = presc + 1'b1;
                    end
                end
                default: begin
                    state_d = MANUAL;
                    presc_d = '0;
                end
            endcase
        end
    end

    assign sel     = sel_q;
    assign disp    = 4'(sel_q);
    assign auto_on = (state == AUTO);

endmodule

// File: tb/tb_scan_mux.sv
module tb_scan_mux;

    logic        clk;
    logic        rst;
    logic        key_next_n;
    logic        key_mode_n;
    logic        load;
    logic [1:0]  sel_in;
    logic [15:0] din4;
    logic [11:0] din3;
    logic [3:0]  f4;
    logic [3:0]  f3;
    logic [1:0]  sel4;
    logic [1:0]  sel3;
    logic [3:0]  disp4;
    logic [3:0]  disp3;
    logic        auto4;
    logic        auto3;

    scan_mux #(.WIDTH(4), .CHANNELS(4), .SCAN_DIV(5)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .din        (din4),
        .key_next_n (key_next_n),
        .key_mode_n (key_mode_n),
        .load       (load),
        .sel_in     (sel_in),
        .f          (f4),
        .sel        (sel4),
        .disp       (disp4),
        .auto_on    (auto4)
    );

    scan_mux #(.WIDTH(4), .CHANNELS(3), .SCAN_DIV(4)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .din        (din3),
        .key_next_n (key_next_n),
        .key_mode_n (key_mode_n),
        .load       (load),
        .sel_in     (sel_in),
        .f          (f3),
        .sel        (sel3),
        .disp       (disp3),
        .auto_on    (auto3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        string tag;
        int    exp;
    } sb_t;
    sb_t sb[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic sb_push(input string tag, input int exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input int got);
        sb_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk(e.tag, got, e.exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int nib4(input int i);
        logic [15:0] v;
        v = din4 >> (4 * i);
        return int'(v[3:0]);
    endfunction

    function automatic int nib3(input int i);
        logic [11:0] v;
        v = din3 >> (4 * i);
        return int'(v[3:0]);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        key_next_n = 1'b1;
        key_mode_n = 1'b1;
        load       = 1'b0;
        sel_in     = 2'd0;
        din4       = {4'hD, 4'hC, 4'hB, 4'hA};
        din3       = {4'h9, 4'h6, 4'h3};

        // Reset values, then first sample of channel 0.
        sb_push("rst_f4", 0);
        sb_push("rst_auto4", 0);
        tick(3);
        sb_pop(f4);
        sb_pop(auto4);
        rst = 1'b0;
        sb_push("init_sel4", 0);
        sb_push("init_disp4", 0);
        sb_push("init_f4", 'hA);
        sb_push("init_auto4", 0);
        sb_push("init_f3", 3);
        tick(3);
        sb_pop(sel4);
        sb_pop(disp4);
        sb_pop(f4);
        sb_pop(auto4);
        sb_pop(f3);

        // Manual stepping: four held presses, latency and single step each.
        for (int k = 1; k <= 4; k++) begin
            key_next_n = 1'b0;
            sb_push("next_lat_sel4", (k - 1) % 4);
            tick(2);
            sb_pop(sel4);
            sb_push("next_sel4", k % 4);
            sb_push("next_disp4", k % 4);
            sb_push("next_sel3", k % 3);
            sb_push("next_f4_old", nib4((k - 1) % 4));
            tick(1);
            sb_pop(sel4);
            sb_pop(disp4);
            sb_pop(sel3);
            sb_pop(f4);
            sb_push("next_f4", nib4(k % 4));
            sb_push("next_f3", nib3(k % 3));
            tick(1);
            sb_pop(f4);
            sb_pop(f3);
            sb_push("next_hold_sel4", k % 4);
            tick(6);
            sb_pop(sel4);
            key_next_n = 1'b1;
            tick(5);
        end

        // Load collides with a key_next pulse: load wins.
        key_next_n = 1'b0;
        tick(2);
        load   = 1'b1;
        sel_in = 2'd2;
        sb_push("load_win_sel4", 2);
        sb_push("load_win_sel3", 2);
        tick(1);
        load = 1'b0;
        sb_pop(sel4);
        sb_pop(sel3);
        sb_push("load_win_f4", 'hC);
        tick(1);
        sb_pop(f4);
        key_next_n = 1'b1;
        sb_push("load_hold_sel4", 2);
        tick(5);
        sb_pop(sel4);

        // Out-of-range load only for the 3-channel instance.
        load   = 1'b1;
        sel_in = 2'd3;
        sb_push("load3_sel4", 3);
        sb_push("load3_sel3_ignored", 2);
        tick(1);
        load = 1'b0;
        sb_pop(sel4);
        sb_pop(sel3);
        tick(1);

        // Auto scan; key_next presses must be ignored.
        load   = 1'b1;
        sel_in = 2'd0;
        tick(1);
        load       = 1'b0;
        key_mode_n = 1'b0;
        sb_push("auto_on4", 1);
        sb_push("auto_on3", 1);
        sb_push("auto_t0_sel3", 0);
        tick(3);
        sb_pop(auto4);
        sb_pop(auto3);
        sb_pop(sel3);
        key_next_n = 1'b0;
        sb_push("auto_t4_sel3", 1);
        sb_push("auto_t4_sel4", 0);
        tick(4);
        sb_pop(sel3);
        sb_pop(sel4);
        key_next_n = 1'b1;
        key_mode_n = 1'b1;
        sb_push("auto_t8_sel3", 2);
        sb_push("auto_t8_sel4", 1);
        tick(4);
        sb_pop(sel3);
        sb_pop(sel4);
        sb_push("auto_t12_sel3", 0);
        sb_push("auto_t12_sel4", 2);
        tick(4);
        sb_pop(sel3);
        sb_pop(sel4);
        sb_push("auto_t13_f4", 'hC);
        sb_push("auto_t13_f3", 3);
        sb_push("auto_t13_on3", 1);
        tick(1);
        sb_pop(f4);
        sb_pop(f3);
        sb_pop(auto3);

        // Reset mid-scan with key_mode held through release.
        rst        = 1'b1;
        key_mode_n = 1'b0;
        sb_push("rstauto_on4", 0);
        sb_push("rstauto_on3", 0);
        sb_push("rstauto_sel3", 0);
        sb_push("rstauto_sel4", 0);
        sb_push("rstauto_f4", 0);
        sb_push("rstauto_f3", 0);
        tick(2);
        sb_pop(auto4);
        sb_pop(auto3);
        sb_pop(sel3);
        sb_pop(sel4);
        sb_pop(f4);
        sb_pop(f3);
        rst = 1'b0;
        sb_push("held_no_toggle4", 0);
        sb_push("held_no_toggle3", 0);
        tick(10);
        sb_pop(auto4);
        sb_pop(auto3);
        key_mode_n = 1'b1;
        tick(4);
        key_mode_n = 1'b0;
        sb_push("repress_on4", 1);
        tick(3);
        sb_pop(auto4);
        key_mode_n = 1'b1;
        tick(3);
        key_mode_n = 1'b0;
        sb_push("repress_off4", 0);
        sb_push("repress_off3", 0);
        tick(3);
        sb_pop(auto4);
        sb_pop(auto3);
        key_mode_n = 1'b1;
        tick(3);

        // Bounce: L,H,L,H,L,H then steady L gives four synchronised falls.
        load   = 1'b1;
        sel_in = 2'd1;
        tick(1);
        load = 1'b0;
        sb_push("bounce_sel4", (1 + 4) % 4);
        sb_push("bounce_sel3", (1 + 4) % 3);
        for (int i = 0; i < 6; i++) begin
            key_next_n = ((i % 2) != 0);
            tick(1);
            chk("bounce_range3", int'(sel3 < 2'd3), 1);
        end
        key_next_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("bounce_range3", int'(sel3 < 2'd3), 1);
        end
        sb_pop(sel4);
        sb_pop(sel3);
        key_next_n = 1'b1;
        tick(3);

        chk("sb_left", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
